uart_imem_loader: RTL and testbench

UART-driven program loader that writes 32-bit instructions into instruction memory through its write port, the port that instruction fetch never uses. Sits between the UART receiver/transmitter and instruction memory. Holds the CPU pipeline disabled while a program image is streaming in, then acknowledges over UART and releases the pipeline. Re-arms on a new sync byte so the host can reload without a board reset.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/word_packer.sv | 44 ++++
 rtl/uart_imem_loader.sv | 171 +++++++++++++++++
 tb/tb_uart_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the UART instruction-memory loader.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLenHi = 3'd1,
        StLenLo = 3'd2,
        StData  = 3'd3,
        StResp  = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Default framing bytes
    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam logic [7:0] ACK_DEF  = 8'h06;
    localparam logic [7:0] NAK_DEF  = 8'h15;

    // Width of the big-endian word count in the frame header
    localparam int LEN_W = 16;

endpackage

// File: rtl/word_packer.sv
// Packs a stream of bytes (MSB first) into 32-bit words.
// word/word_valid are registered: word_valid pulses the cycle after the 4th byte.
module word_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  data_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] shift_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic        valid_q;

    // Shift in bytes, latch the completed word and pulse valid on every 4th byte
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end else if (byte_valid) begin
                shift_q <= {shift_q[23:0], data_byte};
                cnt_q   <= cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    word_q  <= {shift_q[23:0], data_byte};
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/uart_imem_loader.sv
// UART program loader: receives SYNC, 16-bit word count and the image, writes it into
// instruction memory, answers ACK/NAK and holds the CPU disabled while loading.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  SYNC   = SYNC_DEF,
    parameter logic [7:0]  ACK    = ACK_DEF,
    parameter logic [7:0]  NAK    = NAK_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_enable,
    output logic              load_done,
    output logic              busy
);

    localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(2**ADDR_W);

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_m1_q, len_m1_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              resp_ack_q, resp_ack_d;
    logic              cpu_en_q, cpu_en_d;
    logic              load_done_q, load_done_d;
    logic              busy_q, busy_d;
    logic              pack_clear;
    logic [31:0]       pack_word;
    logic              pack_valid;
    logic [LEN_W-1:0]  len_rx;

    assign len_rx = {len_hi_q, rx_data};

    word_packer u_packer (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (pack_clear),
        .byte_valid (rx_done && (state_q == StData)),
        .data_byte  (rx_data),
        .word       (pack_word),
        .word_valid (pack_valid)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_m1_d    = len_m1_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        resp_ack_d  = resp_ack_q;
        cpu_en_d    = cpu_en_q;
        load_done_d = load_done_q;
        pack_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_done && rx_data == SYNC) state_d = StLenHi;
            end
            StLenHi: begin
                if (rx_done) begin
                    len_hi_d = rx_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (rx_done) begin
                    if ({1'b0, len_rx} > DEPTH) begin
                        tx_data_d  = NAK;
                        resp_ack_d = 1'b0;
                        tx_start_d = 1'b1;
                        state_d    = StResp;
                    end else if (len_rx == '0) begin
                        tx_data_d  = ACK;
                        resp_ack_d = 1'b1;
                        tx_start_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        len_m1_d   = len_rx - LEN_W'(1);
                        idx_d      = '0;
                        pack_clear = 1'b1;
                        state_d    = StData;
                    end
                end
            end
            StData: begin
                // Write happens this cycle; index moves on afterwards except after the
                // last word, so mem_addr never wraps for a full-depth image.
                if (pack_valid) begin
                    if (LEN_W'(idx_q) == len_m1_q) begin
                        tx_data_d  = ACK;
                        resp_ack_d = 1'b1;
                        tx_start_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            StResp: begin
                // tx_done coinciding with our own tx_start cannot belong to this byte
                if (tx_done && !tx_start_q) begin
                    if (resp_ack_q) begin
                        cpu_en_d    = 1'b1;
                        load_done_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                if (rx_done && rx_data == SYNC) begin
                    cpu_en_d    = 1'b0;
                    load_done_d = 1'b0;
                    state_d     = StLenHi;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = !(state_d == StIdle || state_d == StDone);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_hi_q    <= '0;
            len_m1_q    <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            resp_ack_q  <= 1'b0;
            cpu_en_q    <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_m1_q    <= len_m1_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            resp_ack_q  <= resp_ack_d;
            cpu_en_q    <= cpu_en_d;
            load_done_q <= load_done_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign mem_we     = pack_valid;
    assign mem_addr   = idx_q;
    assign mem_din    = pack_word;
    assign cpu_enable = cpu_en_q;
    assign load_done  = load_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed self-checking bench for uart_imem_loader.
module tb_uart_imem_loader;

    logic        clock;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        cpu_enable;
    logic        load_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    uart_imem_loader #(
        .ADDR_W (10),
        .SYNC   (8'hA5),
        .ACK    (8'h06),
        .NAK    (8'h15)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_enable (cpu_enable),
        .load_done  (load_done),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every cycle with a memory write
    always @(negedge clock) if (mem_we === 1'b1) wr_count++;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive a byte strobe for one clock; rx_done stays high so calls chain back-to-back
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clock);
    endtask

    task automatic stop_bytes();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_tx_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_tx_start_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        check({tag, "_mem_din"}, mem_din, 32'd0);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_cpu_enable"}, {31'd0, cpu_enable}, 32'd0);
        check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int wr_before;
        logic [31:0] w;
        reset_n = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("reset");

        // Non-SYNC bytes in IDLE are ignored
        send_byte(8'h11);
        send_byte(8'h22);
        stop_bytes();
        @(negedge clock);
        check("idle_ignore_busy", {31'd0, busy}, 32'd0);
        check("idle_ignore_tx_start", {31'd0, tx_start}, 32'd0);
        #1 check("idle_ignore_writes", wr_count, 32'd0);

        // Two-word load, bytes back-to-back
        send_byte(8'hA5);
        check("sync_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        check("w0_no_early_we", {31'd0, mem_we}, 32'd0);
        send_byte(8'hEF);
        check("w0_we", {31'd0, mem_we}, 32'd1);
        check("w0_addr", {22'd0, mem_addr}, 32'd0);
        check("w0_din", mem_din, 32'hDEADBEEF);
        send_byte(8'h01);
        check("w0_we_one_cycle", {31'd0, mem_we}, 32'd0);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h67);
        stop_bytes();
        check("w1_we", {31'd0, mem_we}, 32'd1);
        check("w1_addr", {22'd0, mem_addr}, 32'd1);
        check("w1_din", mem_din, 32'h01234567);
        wait_tx_start("ack2");
        check("ack2_tx_data", {24'd0, tx_data}, 32'h06);
        check("ack2_cpu_off", {31'd0, cpu_enable}, 32'd0);
        // tx_done in the tx_start cycle must be ignored
        pulse_tx_done();
        check("ack2_start_one_cycle", {31'd0, tx_start}, 32'd0);
        check("early_done_ignored_busy", {31'd0, busy}, 32'd1);
        check("early_done_ignored_cpu", {31'd0, cpu_enable}, 32'd0);
        pulse_tx_done();
        check("ack2_cpu_enable", {31'd0, cpu_enable}, 32'd1);
        check("ack2_load_done", {31'd0, load_done}, 32'd1);
        check("ack2_busy", {31'd0, busy}, 32'd0);
        #1 check("ack2_writes", wr_count, 32'd2);

        // Length too large -> NAK, back to IDLE with CPU held
        send_byte(8'hA5);
        check("nak_sync_cpu_drop", {31'd0, cpu_enable}, 32'd0);
        check("nak_sync_load_done_drop", {31'd0, load_done}, 32'd0);
        send_byte(8'h04);
        send_byte(8'h01);
        stop_bytes();
        wait_tx_start("nak");
        check("nak_tx_data", {24'd0, tx_data}, 32'h15);
        @(negedge clock);
        pulse_tx_done();
        check("nak_cpu_enable", {31'd0, cpu_enable}, 32'd0);
        check("nak_load_done", {31'd0, load_done}, 32'd0);
        check("nak_busy", {31'd0, busy}, 32'd0);
        #1 check("nak_no_writes", wr_count, 32'd2);
        @(negedge clock);

        // Zero-length image -> immediate ACK
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        stop_bytes();
        wait_tx_start("zero");
        check("zero_tx_data", {24'd0, tx_data}, 32'h06);
        @(negedge clock);
        pulse_tx_done();
        check("zero_cpu_enable", {31'd0, cpu_enable}, 32'd1);
        check("zero_load_done", {31'd0, load_done}, 32'd1);
        #1 check("zero_no_writes", wr_count, 32'd2);

        // Full-depth image: 1024 words, back-to-back bytes
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC000_0000 | 32'(i * 3);
            send_byte(w[31:24]);
            send_byte(w[23:16]);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
            checks++;
            assert (mem_we === 1'b1 && mem_addr === 10'(i) && mem_din === w) else begin
                errors++;
                $error("FAIL full_word: got we=%b addr=%h din=%h want we=1 addr=%h din=%h",
                       mem_we, mem_addr, mem_din, 10'(i), w);
            end
        end
        stop_bytes();
        wait_tx_start("full");
        check("full_tx_data", {24'd0, tx_data}, 32'h06);
        check("full_addr_no_wrap", {22'd0, mem_addr}, 32'h3FF);
        @(negedge clock);
        pulse_tx_done();
        check("full_cpu_enable", {31'd0, cpu_enable}, 32'd1);
        #1 check("full_writes", wr_count, 32'd1026);

        // One-word reload from DONE
        send_byte(8'hA5);
        stop_bytes();
        check("reload_cpu_drop", {31'd0, cpu_enable}, 32'd0);
        check("reload_load_done_drop", {31'd0, load_done}, 32'd0);
        check("reload_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        stop_bytes();
        check("one_we", {31'd0, mem_we}, 32'd1);
        check("one_addr", {22'd0, mem_addr}, 32'd0);
        check("one_din", mem_din, 32'h12345678);
        wait_tx_start("one");
        @(negedge clock);
        pulse_tx_done();
        check("one_cpu_enable", {31'd0, cpu_enable}, 32'd1);

        // SYNC in DONE, partial word, then asynchronous reset
        send_byte(8'hA5);
        check("rst_sync_cpu_drop", {31'd0, cpu_enable}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        stop_bytes();
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        send_byte(8'hCC);
        send_byte(8'hDD);
        stop_bytes();
        repeat (3) @(negedge clock);
        check_all_zero("post_rst");
        #1 check("post_rst_no_write", wr_count, 32'd1027);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
